// File: rtl/uart_pkg.sv
// Shared definitions for the serial link: FSM states, oversampling constants,
// default rates and the parity helper used by both receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } uart_state_e;

  localparam int unsigned OSR       = 16;
  localparam int unsigned SAMPLE_LO = 7;
  localparam int unsigned SAMPLE_HI = 9;

  localparam int unsigned DEF_CLK_FREQ = 1_600_000;
  localparam int unsigned DEF_BAUD     = 10_000;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable so
// the tick phase can be aligned to an external event.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV = DEF_CLK_FREQ / (DEF_BAUD * OSR)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST) && !restart;
    cnt_d = cnt_q + CW'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8-bit UART receiver: 16x oversampling with 3-sample majority vote, error
// detection and a one-entry ready/valid holding register.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OSR);
  localparam logic [3:0] TICK_LO   = 4'(SAMPLE_LO);
  localparam logic [3:0] TICK_MID  = 4'(SAMPLE_LO + 1);
  localparam logic [3:0] TICK_HI   = 4'(SAMPLE_HI);
  localparam logic [3:0] TICK_LAST = 4'(OSR - 1);

  uart_state_e state_q, state_d;
  logic       rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic       armed_q, armed_d;
  logic [3:0] tick_idx_q, tick_idx_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       smp_lo_q, smp_lo_d, smp_mid_q, smp_mid_d;
  logic       par_err_q, par_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, rx_done_q, rx_done_d;
  logic       frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic       overrun_q, overrun_d, busy_q, busy_d;
  logic       tick, restart, maj, commit;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    armed_d      = armed_q;
    tick_idx_d   = tick_idx_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    smp_lo_d     = smp_lo_q;
    smp_mid_d    = smp_mid_q;
    par_err_d    = par_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    restart      = 1'b0;
    commit       = 1'b0;

    // Third vote is the live sample at SAMPLE_HI, so the decision needs no extra cycle
    maj = (smp_lo_q & smp_mid_q) | (smp_lo_q & rx_sync_q) | (smp_mid_q & rx_sync_q);

    if ((state_q != S_IDLE) && tick) begin
      tick_idx_d = tick_idx_q + 4'd1;
      if (tick_idx_q == TICK_LO)  smp_lo_d  = rx_sync_q;
      if (tick_idx_q == TICK_MID) smp_mid_d = rx_sync_q;
    end

    case (state_q)
      S_IDLE: begin
        tick_idx_d = '0;
        bit_idx_d  = '0;
        if (!armed_q) begin
          armed_d = rx_sync_q;
        end else if (!rx_sync_q) begin
          state_d   = S_START;
          restart   = 1'b1;
          armed_d   = 1'b0;
          par_err_d = 1'b0;
        end
      end
      S_START: if (tick) begin
        if ((tick_idx_q == TICK_HI) && maj) state_d = S_IDLE;
        else if (tick_idx_q == TICK_LAST)   state_d = S_DATA;
      end
      S_DATA: if (tick) begin
        if (tick_idx_q == TICK_HI) shift_d = {maj, shift_q[7:1]};
        if (tick_idx_q == TICK_LAST) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (tick) begin
        if (tick_idx_q == TICK_HI)   par_err_d = (maj != parity_bit(shift_q, PARITY_ODD));
        if (tick_idx_q == TICK_LAST) state_d = S_STOP;
      end
      S_STOP: if (tick && (tick_idx_q == TICK_HI)) begin
        if (!maj) begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_HIGH;
        end else if (par_err_q) begin
          parity_err_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_HIGH: if (rx_sync_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
        rx_done_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      armed_q      <= 1'b0;
      tick_idx_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      smp_lo_q     <= 1'b0;
      smp_mid_q    <= 1'b0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      armed_q      <= armed_d;
      tick_idx_q   <= tick_idx_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      smp_lo_q     <= smp_lo_d;
      smp_mid_q    <= smp_mid_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8N1 instance plus an even-parity instance.
module tb_uart_rx_oversampled;

  localparam int BIT = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b0;

  logic [7:0] data0, data1;
  logic valid0, done0, ferr0, perr0, ovr0, busy0;
  logic valid1, done1, ferr1, perr1, ovr1, busy1;

  uart_rx_oversampled u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(data0), .rx_valid(valid0),
    .rx_ready(rdy0), .rx_done(done0), .frame_err(ferr0), .parity_err(perr0),
    .overrun(ovr0), .busy(busy0)
  );

  uart_rx_oversampled #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(data1), .rx_valid(valid1),
    .rx_ready(rdy1), .rx_done(done1), .frame_err(ferr1), .parity_err(perr1),
    .overrun(ovr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done0 = 0, n_ferr0 = 0, n_perr0 = 0, n_ovr0 = 0, n_coinc = 0;
  int n_done1 = 0, n_perr1 = 0;
  int t_rise = 0;
  logic vprev = 1'b0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (done0) begin
      n_done0 <= n_done0 + 1;
      got.push_back(data0);
    end
    if (ferr0) n_ferr0 <= n_ferr0 + 1;
    if (perr0) n_perr0 <= n_perr0 + 1;
    if (ovr0)  n_ovr0  <= n_ovr0 + 1;
    if ((done0 && (ferr0 || perr0 || ovr0)) || (done1 && (ferr1 || perr1 || ovr1)))
      n_coinc <= n_coinc + 1;
    if (done1) n_done1 <= n_done1 + 1;
    if (perr1) n_perr1 <= n_perr1 + 1;
    if (valid0 && !vprev) t_rise <= cyc;
    vprev <= valid0;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int inst, input logic v);
    if (inst == 0) rx0 = v;
    else           rx1 = v;
    idle(BIT);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic par_en,
                            input logic par, input logic stopb);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (par_en) drive_bit(inst, par);
    drive_bit(inst, stopb);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int b, dn, fe, ov, pe, t_fall;
    logic [7:0] exp_b[10];

    // Reset state
    idle(4);
    chk("rst_data", 32'(data0), 32'h00);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_pulses", 32'({done0, ferr0, perr0, ovr0}), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single 8N1 byte with latency check
    b = got.size();
    t_fall = cyc;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("t1_done_cnt", 32'(n_done0), 32'd1);
    chk("t1_byte", 32'(got[b]), 32'hA5);
    chk("t1_latency_in_1520_1545", 32'((t_rise - t_fall >= 1520) && (t_rise - t_fall <= 1545)), 32'd1);
    chk("t1_errs", 32'(n_ferr0 + n_perr0 + n_ovr0), 32'd0);

    // Ten back-to-back bytes
    b = got.size();
    for (int i = 0; i < 10; i++) exp_b[i] = 8'($urandom_range(10, 200));
    for (int i = 0; i < 10; i++) send_frame(0, exp_b[i], 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("t2_count", 32'(got.size() - b), 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("t2_byte%0d", i), 32'(got[b + i]), 32'(exp_b[i]));
    chk("t2_overrun", 32'(n_ovr0), 32'd0);

    // 40-clock low glitch
    dn = n_done0;
    fe = n_ferr0;
    rx0 = 1'b0;
    idle(20);
    chk("t3_busy_during", 32'(busy0), 32'd1);
    idle(20);
    rx0 = 1'b1;
    idle(300);
    chk("t3_busy_after", 32'(busy0), 32'd0);
    chk("t3_no_pulses", 32'((n_done0 - dn) + (n_ferr0 - fe) + n_perr0), 32'd0);

    // Framing error then long break, then recovery
    dn = n_done0;
    fe = n_ferr0;
    b = got.size();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(2000);
    chk("t4_busy_break", 32'(busy0), 32'd1);
    chk("t4_ferr", 32'(n_ferr0 - fe), 32'd1);
    chk("t4_no_commit", 32'(n_done0 - dn), 32'd0);
    rx0 = 1'b1;
    idle(100);
    chk("t4_idle_again", 32'(busy0), 32'd0);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("t4_done", 32'(n_done0 - dn), 32'd1);
    chk("t4_byte", 32'(got[b]), 32'h55);
    chk("t4_ferr_once", 32'(n_ferr0 - fe), 32'd1);

    // Even parity: wrong then right parity bit for 8'h07
    pe = n_perr1;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(20);
    chk("t5_perr", 32'(n_perr1 - pe), 32'd1);
    chk("t5_valid_low", 32'(valid1), 32'd0);
    chk("t5_no_done", 32'(n_done1), 32'd0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    idle(20);
    chk("t5_valid", 32'(valid1), 32'd1);
    chk("t5_data", 32'(data1), 32'h07);
    chk("t5_perr_once", 32'(n_perr1 - pe), 32'd1);

    // Overrun with consumer stalled
    rdy0 = 1'b0;
    dn = n_done0;
    ov = n_ovr0;
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("t6_data_held", 32'(data0), 32'h11);
    chk("t6_valid", 32'(valid0), 32'd1);
    chk("t6_overrun", 32'(n_ovr0 - ov), 32'd1);
    chk("t6_done", 32'(n_done0 - dn), 32'd1);

    // Reset in the middle of a third frame
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    rst_n = 1'b0;
    idle(1);
    chk("t6_rst_data", 32'(data0), 32'h00);
    chk("t6_rst_flags", 32'({valid0, busy0, done0, ferr0, perr0, ovr0}), 32'd0);
    chk("t6_rst_inst1_valid", 32'(valid1), 32'd0);
    rx0 = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(100);
    fe = n_ferr0;
    ov = n_ovr0;
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    idle(20);
    chk("t6_after_data", 32'(data0), 32'h33);
    chk("t6_after_valid", 32'(valid0), 32'd1);
    chk("t6_after_errs", 32'((n_ferr0 - fe) + (n_ovr0 - ov)), 32'd0);
    chk("no_err_with_done", 32'(n_coinc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
